// File: rtl/md_issue_ctrl.sv
// Issue controller between the execute stage and the multdiv unit.
// Latency: issue -> START pulse 1 cycle; writeback 1 cycle after ready or timeout.
// Backpressure: stall is registered and high in START and BUSY. flush aborts the op.
module md_issue_ctrl #(
  parameter int TIMEOUT = 40,
  parameter int RSTATUS = 30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_is_div,
  input  logic [4:0]  issue_rd,
  input  logic [31:0] issue_opA,
  input  logic [31:0] issue_opB,
  input  logic        flush,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception
);

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

  localparam logic [5:0] CNT_LAST  = 6'(TIMEOUT - 1);
  localparam logic [4:0] RS_REG    = 5'(RSTATUS);
  localparam logic [31:0] CODE_MUL = 32'd4;
  localparam logic [31:0] CODE_DIV = 32'd5;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        is_div_q;
  logic [4:0]  rd_q;
  logic [31:0] opa_q, opb_q;
  logic        mult_q, div_q;
  logic        stall_q;
  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        wb_exc_q;

  logic accept;
  logic rdy_ok;
  logic timeout_hit;
  logic finish;

  // Next-state and counter decode; flush always wins over a new issue.
  always_comb begin
    accept      = issue_valid & ~flush;
    rdy_ok      = md_resultRDY & (cnt_q != 6'd0);
    timeout_hit = (cnt_q == CNT_LAST);
    finish      = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = START;
      end
      START: begin
        cnt_d   = 6'd0;
        state_d = flush ? IDLE : BUSY;
      end
      BUSY: begin
        cnt_d = cnt_q + 6'd1;
        if (flush) begin
          state_d = IDLE;
        end else if (rdy_ok || timeout_hit) begin
          state_d = DONE;
          finish  = 1'b1;
        end
      end
      DONE: begin
        state_d = accept ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand latch and registered outputs derived from the state being entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 6'd0;
      is_div_q   <= 1'b0;
      rd_q       <= 5'd0;
      opa_q      <= 32'd0;
      opb_q      <= 32'd0;
      mult_q     <= 1'b0;
      div_q      <= 1'b0;
      stall_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'd0;
      wb_exc_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stall_q    <= (state_d == START) || (state_d == BUSY);
      mult_q     <= 1'b0;
      div_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'd0;
      wb_exc_q   <= 1'b0;
      if (((state_q == IDLE) || (state_q == DONE)) && accept) begin
        is_div_q <= issue_is_div;
        rd_q     <= issue_rd;
        opa_q    <= issue_opA;
        opb_q    <= issue_opB;
        div_q    <= issue_is_div;
        mult_q   <= ~issue_is_div;
      end
      if (finish) begin
        wb_valid_q <= 1'b1;
        // A real ready in the timeout cycle still reports the unit's own result.
        if (rdy_ok && !md_exception) begin
          wb_rd_q   <= rd_q;
          wb_data_q <= md_result;
          wb_exc_q  <= 1'b0;
        end else begin
          wb_rd_q   <= RS_REG;
          wb_data_q <= is_div_q ? CODE_DIV : CODE_MUL;
          wb_exc_q  <= 1'b1;
        end
      end
    end
  end

  // A flush arriving in START or DONE must kill the pulse / writeback in that same cycle.
  always_comb begin
    md_ctrl_MULT = mult_q & ~flush;
    md_ctrl_DIV  = div_q & ~flush;
    wb_valid     = wb_valid_q & ~flush;
  end

  assign md_operandA  = opa_q;
  assign md_operandB  = opb_q;
  assign stall        = stall_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign wb_exception = wb_exc_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Randomized and directed bench for md_issue_ctrl against a transaction-level reference.
// The reference tracks the in-flight op by its BUSY-cycle ordinal and a pending writeback.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_md_issue_ctrl;

  localparam int TIMEOUT = 40;
  localparam int RSTATUS = 30;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_is_div = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [31:0] issue_opA = '0;
  logic [31:0] issue_opB = '0;
  logic        flush = 1'b0;
  logic [31:0] md_operandA, md_operandB;
  logic        md_ctrl_MULT, md_ctrl_DIV;
  logic [31:0] md_result = '0;
  logic        md_exception = 1'b0;
  logic        md_resultRDY = 1'b0;
  logic        stall, wb_valid, wb_exception;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  md_issue_ctrl #(.TIMEOUT(TIMEOUT), .RSTATUS(RSTATUS)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_is_div(issue_is_div), .issue_rd(issue_rd),
    .issue_opA(issue_opA), .issue_opB(issue_opB), .flush(flush),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
    .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
    .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_exception(wb_exception)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: op in flight (busy) and which cycle of it we are in (0 = start, k = k-th BUSY).
  bit          m_busy = 0;
  int          m_age = 0;
  bit          m_div = 0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_a = '0, m_b = '0;
  bit          m_wb = 0;
  logic [4:0]  m_wrd = '0;
  logic [31:0] m_wdata = '0;
  bit          m_wexc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_mult"}, md_ctrl_MULT, 0);
    chk({tag, "_div"}, md_ctrl_DIV, 0);
    chk({tag, "_opA"}, md_operandA, 0);
    chk({tag, "_opB"}, md_operandB, 0);
    chk({tag, "_wbv"}, wb_valid, 0);
    chk({tag, "_wbrd"}, wb_rd, 0);
    chk({tag, "_wbdata"}, wb_data, 0);
    chk({tag, "_wbexc"}, wb_exception, 0);
  endtask

  task automatic check_model();
    chk("stall", stall, m_busy);
    chk("mult_pulse", md_ctrl_MULT, m_busy && m_age == 0 && !m_div && !flush);
    chk("div_pulse", md_ctrl_DIV, m_busy && m_age == 0 && m_div && !flush);
    chk("wb_valid", wb_valid, m_wb && !flush);
    chk("wb_rd", wb_rd, m_wb ? m_wrd : 5'd0);
    chk("wb_data", wb_data, m_wb ? m_wdata : 32'd0);
    chk("wb_exc", wb_exception, m_wb ? m_wexc : 1'b0);
    if (m_busy) begin
      chk("opA_hold", md_operandA, m_a);
      chk("opB_hold", md_operandB, m_b);
    end
  endtask

  task automatic model_finish(input bit exc, input logic [31:0] res);
    m_busy = 0;
    m_wb   = 1;
    if (exc) begin
      m_wrd   = 5'(RSTATUS);
      m_wdata = m_div ? 32'd5 : 32'd4;
      m_wexc  = 1;
    end else begin
      m_wrd   = m_rd;
      m_wdata = res;
      m_wexc  = 0;
    end
  endtask

  task automatic model_step();
    m_wb = 0;
    if (m_busy) begin
      if (flush) m_busy = 0;
      else if (m_age == 0) m_age = 1;
      else if (md_resultRDY && m_age >= 2) model_finish(md_exception, md_result);
      else if (m_age == TIMEOUT) model_finish(1, 32'd0);
      else m_age++;
    end else if (issue_valid && !flush) begin
      m_busy = 1;
      m_age  = 0;
      m_div  = issue_is_div;
      m_rd   = issue_rd;
      m_a    = issue_opA;
      m_b    = issue_opB;
    end
  endtask

  task automatic cyc(input logic iv, input logic dv, input logic [4:0] rd,
                     input logic [31:0] a, input logic [31:0] b, input logic fl,
                     input logic rdy, input logic [31:0] res, input logic ex);
    @(posedge clock);
    #1;
    issue_valid = iv; issue_is_div = dv; issue_rd = rd; issue_opA = a; issue_opB = b;
    flush = fl; md_resultRDY = rdy; md_result = res; md_exception = ex;
    @(negedge clock);
    check_model();
    model_step();
  endtask

  task automatic idle_cyc(input logic rdy);
    cyc(0, 0, 5'd0, 32'd0, 32'd0, 0, rdy, 32'd0, 0);
  endtask

  task automatic do_reset_async(input string tag);
    @(posedge clock);
    #3;
    issue_valid = 0; flush = 0; md_resultRDY = 0; md_exception = 0;
    reset = 1;
    #1;
    check_all_zero(tag);
    @(posedge clock);
    #2;
    reset = 0;
    m_busy = 0;
    m_wb   = 0;
  endtask

  int rdy_pct;
  int pct_tab[5] = '{50, 10, 3, 0, 20};

  initial begin
    #1 reset = 1;
    #2 check_all_zero("reset");
    @(posedge clock);
    #2 reset = 0;

    // Multiply 6 x 7, ready on the 17th BUSY cycle.
    cyc(1, 0, 5'd5, 32'd6, 32'd7, 0, 0, 32'd0, 0);
    idle_cyc(0);
    chk("mul_start_pulse", md_ctrl_MULT, 1);
    chk("mul_start_nodiv", md_ctrl_DIV, 0);
    chk("mul_start_stall", stall, 1);
    for (int k = 1; k <= 16; k++) idle_cyc(0);
    chk("mul_busy16_stall", stall, 1);
    cyc(0, 0, 5'd0, 32'd0, 32'd0, 0, 1, 32'd42, 0);
    idle_cyc(0);
    chk("mul_wb_valid", wb_valid, 1);
    chk("mul_wb_rd", wb_rd, 5);
    chk("mul_wb_data", wb_data, 42);
    chk("mul_wb_exc", wb_exception, 0);
    chk("mul_done_stall", stall, 0);
    idle_cyc(0);

    // Divide 7/0 with exception, then back-to-back issue in DONE with ready held high.
    cyc(1, 1, 5'd9, 32'd7, 32'd0, 0, 0, 32'd0, 0);
    idle_cyc(0);
    chk("div_start_pulse", md_ctrl_DIV, 1);
    chk("div_start_nomult", md_ctrl_MULT, 0);
    idle_cyc(0);
    idle_cyc(0);
    cyc(0, 0, 5'd0, 32'd0, 32'd0, 0, 1, 32'hdead, 1);
    cyc(1, 1, 5'd12, 32'd100, 32'd4, 0, 1, 32'd0, 0);
    chk("divexc_wb_valid", wb_valid, 1);
    chk("divexc_wb_rd", wb_rd, 30);
    chk("divexc_wb_data", wb_data, 5);
    chk("divexc_wb_exc", wb_exception, 1);
    cyc(0, 0, 5'd0, 32'd0, 32'd0, 0, 1, 32'd0, 0);
    chk("b2b_start_pulse", md_ctrl_DIV, 1);
    cyc(0, 0, 5'd0, 32'd0, 32'd0, 0, 1, 32'd99, 0);
    idle_cyc(0);
    chk("stale_rdy_ignored", wb_valid, 0);
    chk("stale_rdy_stall", stall, 1);
    cyc(0, 0, 5'd0, 32'd0, 32'd0, 0, 1, 32'd25, 0);
    idle_cyc(0);
    chk("b2b_wb_data", wb_data, 25);
    chk("b2b_wb_rd", wb_rd, 12);
    idle_cyc(0);

    // Multiply with no ready: forced exception after TIMEOUT BUSY cycles.
    cyc(1, 0, 5'd3, 32'd1, 32'd2, 0, 0, 32'd0, 0);
    idle_cyc(0);
    for (int k = 1; k <= TIMEOUT; k++) idle_cyc(0);
    chk("to_last_busy_nowb", wb_valid, 0);
    idle_cyc(0);
    chk("to_wb_valid", wb_valid, 1);
    chk("to_wb_rd", wb_rd, 30);
    chk("to_wb_data", wb_data, 4);
    chk("to_wb_exc", wb_exception, 1);

    // Flush at BUSY cycle 3, with a ready in the same cycle.
    cyc(1, 0, 5'd7, 32'd3, 32'd3, 0, 0, 32'd0, 0);
    idle_cyc(0);
    idle_cyc(0);
    idle_cyc(0);
    cyc(0, 0, 5'd0, 32'd0, 32'd0, 1, 1, 32'd9, 0);
    idle_cyc(0);
    chk("flush_busy_nowb", wb_valid, 0);
    chk("flush_busy_stall", stall, 0);

    // Flush in DONE drops the writeback and ignores the concurrent issue.
    cyc(1, 1, 5'd4, 32'd8, 32'd2, 0, 0, 32'd0, 0);
    idle_cyc(0);
    idle_cyc(0);
    cyc(0, 0, 5'd0, 32'd0, 32'd0, 0, 1, 32'd4, 0);
    cyc(1, 0, 5'd6, 32'd1, 32'd1, 1, 0, 32'd0, 0);
    chk("flush_done_nowb", wb_valid, 0);
    idle_cyc(0);
    chk("flush_done_noissue", stall, 0);

    // Reset asserted mid-BUSY clears everything asynchronously; next issue starts cleanly.
    cyc(1, 0, 5'd2, 32'd5, 32'd5, 0, 0, 32'd0, 0);
    idle_cyc(0);
    idle_cyc(0);
    idle_cyc(0);
    do_reset_async("rst_busy");
    cyc(1, 0, 5'd0, 32'd11, 32'd3, 0, 0, 32'd0, 0);
    idle_cyc(0);
    chk("post_rst_pulse", md_ctrl_MULT, 1);

    // Randomized traffic with varying ready density, occasional flushes and resets.
    for (int i = 0; i < 3000; i++) begin
      if (i % 600 == 0) rdy_pct = pct_tab[i / 600];
      if ($urandom_range(999) < 2) begin
        do_reset_async("rst_rand");
      end else begin
        cyc($urandom_range(99) < 60, 1'($urandom_range(1)), 5'($urandom_range(31)),
            $urandom, $urandom, $urandom_range(99) < 4, $urandom_range(99) < rdy_pct,
            $urandom, $urandom_range(99) < 20);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
